multicycle_control_unit: RTL and testbench

Multi-cycle successor to the single-cycle RV32I control unit. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB with a Moore FSM and decodes the full RV32I ALU instruction set (R, I-ALU, LOAD, STORE, LUI, AUIPC) into an ALU op and registered ALU operands. It drives the fetch and data-memory handshake strobes and the register-file and PC write enables. It sits between the decoder/register file and the ALU/memory interface.

---
 rtl/multicycle_control_unit.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB with registered ALU operands.
// Latency: 3 cycles instr_valid->pc_we for ALU ops, 2/3 + MEM cycles for store/load; stalls in MEM until mem_ready.
// Optional MULTICYCLE_CU_ILLEGAL_TRAP_EN: unknown opcodes park in a sticky TRAP state instead of retiring as NOP.
module multicycle_control_unit #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic                mem_ready,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7_5,
  input  logic [XLEN-1:0]     rs1_data,
  input  logic [XLEN-1:0]     rs2_data,
  input  logic [XLEN-1:0]     imm,
  input  logic [XLEN-1:0]     pc,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [XLEN-1:0]     alu_a,
  output logic [XLEN-1:0]     alu_b,
  output logic                ir_we,
  output logic                mem_req,
  output logic                mem_we,
  output logic                rf_we,
  output logic                wb_sel,
  output logic                pc_we,
  output logic                busy,
  output logic                illegal_instr
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
  localparam logic [2:0] S_TRAP    = 3'd5;
`endif

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD    = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_SLL    = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_SLT    = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU   = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_XOR    = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SRL    = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_SRA    = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_OR     = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_AND    = ALU_OP_W'(9);
  localparam logic [ALU_OP_W-1:0] ALU_PASS_B = ALU_OP_W'(10);
  localparam logic [ALU_OP_W-1:0] ALU_NULL   = ALU_OP_W'(15);

  logic [2:0]      state, state_nxt;
  logic [6:0]      opcode_q;
  logic [2:0]      funct3_q;
  logic            funct7_5_q;
  logic [XLEN-1:0] dec_a, dec_b;

  function automatic logic is_known(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_LUI) || (op == OP_AUIPC);
  endfunction

  function automatic logic [ALU_OP_W-1:0] f3_op(input logic [2:0] f3, input logic alt);
    logic [ALU_OP_W-1:0] r;
    case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  // alu_op derives from the fields latched in DECODE, so it holds until the next DECODE edge.
  always_comb begin
    alu_op = ALU_NULL;
    case (opcode_q)
      OP_R:                        alu_op = f3_op(funct3_q, funct7_5_q);
      OP_I:                        alu_op = f3_op(funct3_q, funct7_5_q && (funct3_q == 3'b101));
      OP_LOAD, OP_STORE, OP_AUIPC: alu_op = ALU_ADD;
      OP_LUI:                      alu_op = ALU_PASS_B;
      default:                     alu_op = ALU_NULL;
    endcase
  end

  always_comb begin
    dec_a = '0;
    dec_b = '0;
    case (opcode)
      OP_R:                      begin dec_a = rs1_data; dec_b = rs2_data; end
      OP_I, OP_LOAD, OP_STORE:   begin dec_a = rs1_data; dec_b = imm;      end
      OP_LUI:                    begin dec_a = '0;       dec_b = imm;      end
      OP_AUIPC:                  begin dec_a = pc;       dec_b = imm;      end
      default:                   begin dec_a = '0;       dec_b = '0;       end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:   if (instr_valid) state_nxt = S_DECODE;
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
      S_DECODE:  state_nxt = is_known(opcode) ? S_EXECUTE : S_TRAP;
      S_TRAP:    state_nxt = S_TRAP;
`else
      S_DECODE:  state_nxt = S_EXECUTE;
`endif
      S_EXECUTE: begin
        if ((opcode_q == OP_LOAD) || (opcode_q == OP_STORE)) state_nxt = S_MEM;
        else if (!is_known(opcode_q))                          state_nxt = S_FETCH;
        else                                                   state_nxt = S_WB;
      end
      S_MEM:     if (mem_ready) state_nxt = (opcode_q == OP_LOAD) ? S_WB : S_FETCH;
      S_WB:      state_nxt = S_FETCH;
      default:   state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      opcode_q   <= '0;
      funct3_q   <= '0;
      funct7_5_q <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) begin
        opcode_q   <= opcode;
        funct3_q   <= funct3;
        funct7_5_q <= funct7_5;
        alu_a      <= dec_a;
        alu_b      <= dec_b;
      end
    end
  end

  always_comb begin
    ir_we   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    rf_we   = 1'b0;
    wb_sel  = 1'b0;
    pc_we   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = instr_valid;
      end
      S_EXECUTE: pc_we = !is_known(opcode_q);
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opcode_q == OP_STORE);
        pc_we   = mem_ready && (opcode_q == OP_STORE);
      end
      S_WB: begin
        rf_we  = 1'b1;
        wb_sel = (opcode_q == OP_LOAD);
        pc_we  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_FETCH);

`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
  assign illegal_instr = (state == S_TRAP);
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed RV32I cases plus random instruction stream vs a per-instruction model.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        mem_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] rs1_data, rs2_data, imm, pc;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic        ir_we, mem_req, mem_we, rf_we, wb_sel, pc_we, busy, illegal_instr;

  int checks = 0;
  int errors = 0;

`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  multicycle_control_unit #(.XLEN(32), .ALU_OP_W(4)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .mem_ready(mem_ready),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .ir_we(ir_we), .mem_req(mem_req), .mem_we(mem_we), .rf_we(rf_we),
    .wb_sel(wb_sel), .pc_we(pc_we), .busy(busy), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_we, rf_we, wb_sel, pc_we, busy, ir_we}
  logic [6:0] strb;
  assign strb = {mem_req, mem_we, rf_we, wb_sel, pc_we, busy, ir_we};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // kinds: 0 = ALU/LUI/AUIPC, 1 = load, 2 = store, 3 = unknown
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f75, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] im, input logic [31:0] p, input int wait_n);
    logic [3:0]  base_tbl [8];
    logic [3:0]  e_op;
    logic [31:0] e_a, e_b;
    logic [6:0]  exp_q [$];
    int          kind;
    base_tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    kind = 0; e_a = 0; e_b = 0; e_op = 4'd15;
    case (op)
      7'h33: begin e_a = r1; e_b = r2; e_op = base_tbl[f3];
                   if (f75 && f3 == 3'd0) e_op = 4'd1;
                   if (f75 && f3 == 3'd5) e_op = 4'd7; end
      7'h13: begin e_a = r1; e_b = im; e_op = base_tbl[f3];
                   if (f75 && f3 == 3'd5) e_op = 4'd7; end
      7'h03: begin kind = 1; e_a = r1; e_b = im; e_op = 4'd0; end
      7'h23: begin kind = 2; e_a = r1; e_b = im; e_op = 4'd0; end
      7'h37: begin e_a = 0;  e_b = im; e_op = 4'd10; end
      7'h17: begin e_a = p;  e_b = im; e_op = 4'd0; end
      default: kind = 3;
    endcase

    exp_q.push_back(7'b1000001);
    exp_q.push_back(7'b0000010);
    exp_q.push_back((kind == 3) ? 7'b0000110 : 7'b0000010);
    if (kind == 0) exp_q.push_back(7'b0010110);
    if (kind == 1 || kind == 2) begin
      for (int w = 0; w < wait_n; w++) exp_q.push_back((kind == 2) ? 7'b1100010 : 7'b1000010);
      exp_q.push_back((kind == 2) ? 7'b1100110 : 7'b1000010);
      if (kind == 1) exp_q.push_back(7'b0011110);
    end

    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      mem_ready   = 1'($urandom);
      #1;
      chk({name, " idle"}, 32'(strb), 32'(7'b1000000));
    end

    for (int idx = 0; idx < exp_q.size(); idx++) begin
      @(negedge clk);
      opcode = op; funct3 = f3; funct7_5 = f75;
      rs1_data = r1; rs2_data = r2; imm = im; pc = p;
      instr_valid = (idx == 0) ? 1'b1 : 1'($urandom);
      if ((kind == 1 || kind == 2) && idx >= 3 && idx <= 3 + wait_n)
        mem_ready = (idx == 3 + wait_n);
      else
        mem_ready = 1'($urandom);
      #1;
      chk($sformatf("%s strobes@%0d", name, idx), 32'(strb), 32'(exp_q[idx]));
      chk($sformatf("%s illegal@%0d", name, idx), 32'(illegal_instr), 32'd0);
      if (idx >= 2) begin
        chk($sformatf("%s alu_op@%0d", name, idx), 32'(alu_op), 32'(e_op));
        chk($sformatf("%s alu_a@%0d", name, idx), alu_a, e_a);
        chk($sformatf("%s alu_b@%0d", name, idx), alu_b, e_b);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] ops [7];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h7F};
    rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0;
    opcode = 7'h00; funct3 = 3'd0; funct7_5 = 1'b0;
    rs1_data = 0; rs2_data = 0; imm = 0; pc = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset strobes", 32'(strb), 32'(7'b1000000));
    chk("reset alu_op", 32'(alu_op), 32'd15);
    chk("reset alu_a", alu_a, 32'd0);
    chk("reset alu_b", alu_b, 32'd0);
    chk("reset illegal", 32'(illegal_instr), 32'd0);

    run_instr("add",  7'h33, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'h40, 0);
    run_instr("srai", 7'h13, 3'd5, 1'b1, 32'h8000_0000, 32'd9, 32'd3, 32'h44, 0);
    run_instr("sub",  7'h33, 3'd0, 1'b1, 32'd20, 32'd4, 32'd0, 32'h48, 0);
    run_instr("lw",   7'h03, 3'd2, 1'b0, 32'h100, 32'd0, 32'd8, 32'h4C, 3);
    run_instr("sw",   7'h23, 3'd2, 1'b0, 32'h200, 32'h55, 32'd4, 32'h50, 0);
    run_instr("lui",  7'h37, 3'd0, 1'b0, 32'h123, 32'd0, 32'hABCD_E000, 32'h54, 0);
    run_instr("auipc", 7'h17, 3'd0, 1'b0, 32'h123, 32'd0, 32'h0000_1000, 32'h58, 0);
    if (!TRAP_EN) run_instr("unknown", 7'h7F, 3'd0, 1'b0, 32'd1, 32'd2, 32'd3, 32'h5C, 0);

    for (int n = 0; n < 40; n++) begin
      logic [6:0] op_r;
      op_r = ops[$urandom_range(0, TRAP_EN ? 5 : 6)];
      run_instr($sformatf("rnd%0d", n), op_r, 3'($urandom), 1'($urandom),
                $urandom, $urandom, $urandom, $urandom, int'($urandom_range(0, 4)));
    end

    // Reset while a store is waiting in MEM: the store must never retire.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      opcode = 7'h23; funct3 = 3'd2; funct7_5 = 1'b0;
      rs1_data = 32'h300; imm = 32'd4;
      instr_valid = (i == 0); mem_ready = 1'b0;
      #1;
    end
    chk("store stalled mem_we", 32'(mem_we), 32'd1);
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst strobes", 32'(strb), 32'(7'b1000000));
    chk("midrst alu_op", 32'(alu_op), 32'd15);
    chk("midrst alu_a", alu_a, 32'd0);
    chk("midrst alu_b", alu_b, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      chk("midrst no retire", 32'(strb), 32'(7'b1000000));
    end

`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
    @(negedge clk);
    opcode = 7'h7F; instr_valid = 1'b1; mem_ready = 1'b0;
    #1;
    chk("trap fetch", 32'(strb), 32'(7'b1000001));
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    chk("trap decode illegal", 32'(illegal_instr), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      instr_valid = 1'($urandom); mem_ready = 1'($urandom);
      #1;
      chk("trap illegal", 32'(illegal_instr), 32'd1);
      chk("trap strobes", 32'(strb), 32'(7'b0000010));
    end
    @(negedge clk);
    rst = 1'b1; instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("trap cleared illegal", 32'(illegal_instr), 32'd0);
    chk("trap cleared strobes", 32'(strb), 32'(7'b1000000));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
